// File: rtl/timer_irq_master.sv
// Avalon-MM master that programs the interval timer after reset and services its timeout IRQ.
// Clears TO, re-reads status to catch a timeout that raced the clear, counts ticks and rotates an LED chaser.
module timer_irq_master #(
  parameter logic [31:0] PERIOD    = 32'd49999,
  parameter int          LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 irq,
  input  logic [15:0]          readdata,
  input  logic                 led_dir,
  output logic [2:0]           address,
  output logic                 chipselect,
  output logic                 write_n,
  output logic [15:0]          writedata,
  output logic                 init_done,
  output logic [31:0]          tick_count,
  output logic [LED_WIDTH-1:0] leds
);

  typedef enum logic [2:0] {
    S_INIT_PL,
    S_INIT_PH,
    S_INIT_CTRL,
    S_IDLE,
    S_CLR,
    S_RD,
    S_CAP
  } state_t;

  localparam logic [2:0]  ADDR_STATUS = 3'd0;
  localparam logic [2:0]  ADDR_CTRL   = 3'd1;
  localparam logic [2:0]  ADDR_PERL   = 3'd2;
  localparam logic [2:0]  ADDR_PERH   = 3'd3;
  localparam logic [15:0] CTRL_GO     = 16'h0007;

  state_t                 state_q, state_d;
  logic                   init_done_q, init_done_d;
  logic [31:0]            tick_count_q, tick_count_d;
  logic [LED_WIDTH-1:0]   leds_q, leds_d;

  logic                   bus_cs, bus_wn;
  logic [2:0]             bus_addr;
  logic [15:0]            bus_wd;

  // Only the TO bit of the status register matters here.
  logic                   unused_rd;
  assign unused_rd = ^readdata[15:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_INIT_PL;
      init_done_q  <= 1'b0;
      tick_count_q <= 32'd0;
      leds_q       <= LED_WIDTH'(1);
    end else begin
      state_q      <= state_d;
      init_done_q  <= init_done_d;
      tick_count_q <= tick_count_d;
      leds_q       <= leds_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT_PL:   state_d = S_INIT_PH;
      S_INIT_PH:   state_d = S_INIT_CTRL;
      S_INIT_CTRL: state_d = S_IDLE;
      S_IDLE:      state_d = irq ? S_CLR : S_IDLE;
      S_CLR:       state_d = S_RD;
      S_RD:        state_d = S_CAP;
      S_CAP:       state_d = readdata[0] ? S_CLR : S_IDLE;
      default:     state_d = S_INIT_PL;
    endcase
  end

  always_comb begin
    init_done_d  = init_done_q | (state_q == S_INIT_CTRL);
    tick_count_d = tick_count_q;
    leds_d       = leds_q;
    if (state_q == S_CAP) begin
      tick_count_d = tick_count_q + 32'd1;
      leds_d       = led_dir ? {leds_q[0], leds_q[LED_WIDTH-1:1]}
                             : {leds_q[LED_WIDTH-2:0], leds_q[LED_WIDTH-1]};
    end
  end

  always_comb begin
    bus_cs   = 1'b0;
    bus_wn   = 1'b1;
    bus_addr = 3'd0;
    bus_wd   = 16'd0;
    case (state_q)
      S_INIT_PL: begin
        bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = ADDR_PERL; bus_wd = PERIOD[15:0];
      end
      S_INIT_PH: begin
        bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = ADDR_PERH; bus_wd = PERIOD[31:16];
      end
      S_INIT_CTRL: begin
        bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = ADDR_CTRL; bus_wd = CTRL_GO;
      end
      S_CLR: begin
        bus_cs = 1'b1; bus_wn = 1'b0; bus_addr = ADDR_STATUS;
      end
      S_RD: begin
        bus_cs = 1'b1; bus_addr = ADDR_STATUS;
      end
      default: ;
    endcase
  end

  // Reset state is INIT_PL, so the bus is masked while reset is held to keep it idle.
  assign chipselect = bus_cs & reset_n;
  assign write_n    = bus_wn | ~reset_n;
  assign address    = reset_n ? bus_addr : 3'd0;
  assign writedata  = reset_n ? bus_wd : 16'd0;
  assign init_done  = init_done_q;
  assign tick_count = tick_count_q;
  assign leds       = leds_q;

endmodule

// File: doc/timer_irq_master.md
# timer_irq_master

Avalon-MM master that owns the interval timer peripheral and services its interrupt in hardware. Sits directly downstream of the timer: it consumes the timer's `irq`, drives the timer's slave port (address/chipselect/write_n/writedata, readdata back) to program the period and start it after reset, and then clears each timeout, counts ticks and advances an LED chaser without any Nios II involvement.

## Interface
Parameters:
- `PERIOD`, 32'd49999, value loaded into the timer period registers (timer counts PERIOD+1 clocks per tick).
- `LED_WIDTH`, 8, width of the LED chaser output (≥2).

Ports:
- `clk`  in  1  system clock, shared with the timer.
- `reset_n`  in  1  asynchronous, active-low reset.
- `irq`  in  1  timer interrupt, level, registered in the timer.
- `readdata`  in  16  timer slave read data, valid the cycle after the read is presented.
- `led_dir`  in  1  chaser direction: 0 rotate left, 1 rotate right.
- `address`  out  3  timer register address.
- `chipselect`  out  1  timer slave select.
- `write_n`  out  1  active-low write strobe.
- `writedata`  out  16  timer write data.
- `init_done`  out  1  high once the timer has been programmed and started.
- `tick_count`  out  32  number of timeouts serviced.
- `leds`  out  LED_WIDTH  one-hot chaser pattern.

## Operation
- Timer register map used: 0 status (bit0 TO, write clears), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h.
- Bus transactions are single-cycle, no waitrequest: `chipselect`=1 for exactly one cycle per access; `write_n`=0 only in write cycles; `chipselect`=0, `write_n`=1, `address`=0 and `writedata`=0 in every other cycle.
- FSM states and transitions:
  - INIT_PL: write `PERIOD[15:0]` to addr 2 → INIT_PH.
  - INIT_PH: write `PERIOD[31:16]` to addr 3 → INIT_CTRL.
  - INIT_CTRL: write 16'h0007 (ITO|CONT|START) to addr 1 → IDLE; `init_done` rises.
  - IDLE: `irq`=1 → CLR; else stay.
  - CLR: write 16'h0000 to addr 0 → RD.
  - RD: read addr 0 (chipselect=1, write_n=1) → CAP.
  - CAP: sample `readdata`; `tick_count` += 1; `leds` rotate one position per `led_dir`; if `readdata[0]`=1 (new timeout arrived after the clear) → CLR, else → IDLE.
- `tick_count` wraps 32'hFFFF_FFFF → 0 with no flag.
- `leds` rotation wraps MSB↔LSB; exactly one bit set at all times.
- `led_dir` sampled in CAP only.
- `irq` ignored in every state other than IDLE; a timeout during CLR is lost (timer's status write has priority), one during RD/CAP is recovered via the CAP re-check.
- `init_done` stays high until reset; never re-runs INIT without reset.

## Timing
- Reset values: `address`=0, `chipselect`=0, `write_n`=1, `writedata`=0, `init_done`=0, `tick_count`=0, `leds`=1 (LSB), state INIT_PL.
- Reset is asynchronous; assertion mid-transaction drops `chipselect` immediately and returns to INIT_PL; first write appears in the first clock after deassertion.
- Init: writes on cycles 0,1,2 after reset release; `init_done`=1 from cycle 3.
- Service latency: `irq` high in IDLE at cycle t → clear write at t+1 → read at t+2 → CAP at t+3 → `tick_count`/`leds` updated and visible at t+4; IDLE again at t+4. Timer `irq` falls at t+2.
- Back-to-back: when CAP loops to CLR, next clear write is at t+4, next count update at t+7.
- Minimum service interval 4 cycles; PERIOD < 3 is unsupported.

## Test plan
- Reset release with PERIOD=49999 → writes (addr2,16'hC34F),(addr3,16'h0000),(addr1,16'h0007) on three consecutive cycles, `init_done`=1 on the fourth.
- Single `irq` pulse held until cleared, readdata[0]=0 at CAP → one write addr0 data 0, one read addr0, `tick_count` 0→1, `leds` 8'h01→8'h02 exactly 4 cycles after `irq`.
- Real timer connected, PERIOD=9, 5 ticks → `tick_count`=5, `leds`=8'h20, timer irq low within 2 cycles of each rise.
- readdata[0]=1 at CAP (inject timeout) → immediate second CLR/RD/CAP, `tick_count` +2 total, no IDLE cycle between.
- `led_dir`=1 from `leds`=8'h01 → next tick gives 8'h80; `tick_count` preset 32'hFFFF_FFFF via force → next tick 0.
- reset_n asserted during RD → `chipselect`=0 asynchronously, `tick_count`=0, `init_done`=0, init sequence repeats after release.
